// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with 5-8 data bits, optional parity,
// 1/2 stop bits, a single-word holding register and rts_n flow control.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_tick,
    input  logic              rx,
    input  logic [1:0]        data_bit_num_i,
    input  logic              parity_en_i,
    input  logic              parity_type_i,
    input  logic              stop_bit_num_i,
    input  logic              rx_read_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              rx_done_o,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              rts_n
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
    state_t          r_state, w_state_nxt;
    logic            r_rx_meta, r_rx_sync, r_rx_prev;
    logic [TW-1:0]   r_tick_cnt;
    logic [2:0]      r_bit_cnt;
    logic            r_stop_cnt;
    logic [7:0]      r_shift;
    logic [1:0]      r_dbn;
    logic            r_pen, r_ptype, r_sbn;
    logic            r_perr, r_ferr, r_valid;
    logic            w_fall, w_mid, w_bit, w_confirm, w_finish;
    logic [7:0]      w_data;
    // Synchroniser flops reset low so a line held low across reset never looks like a start edge.
    assign w_fall    = r_rx_prev & ~r_rx_sync;
    assign w_mid     = rx_tick && r_tick_cnt == HALF;
    assign w_bit     = rx_tick && r_tick_cnt == FULL;
    assign w_confirm = r_state == START && w_mid && !r_rx_sync;
    // Bits enter at the MSB, so a short word ends up left-aligned and is shifted down.
    assign w_data    = r_shift >> (2'd3 - r_dbn);
    assign rx_done_o  = r_state == DONE;
    assign rx_valid_o = r_valid;
    assign rts_n      = r_valid;
    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        case (r_state)
            IDLE:    w_state_nxt = w_fall ? START : IDLE;
            START:   w_state_nxt = w_mid ? (r_rx_sync ? IDLE : DATA) : START;
            DATA:    w_state_nxt = (w_bit && r_bit_cnt == {1'b1, r_dbn}) ? (r_pen ? PARITY : STOP) : DATA;
            PARITY:  w_state_nxt = w_bit ? STOP : PARITY;
            STOP: begin
                w_finish    = w_bit && r_stop_cnt == r_sbn;
                w_state_nxt = w_finish ? DONE : STOP;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rx_meta    <= 1'b0;
            r_rx_sync    <= 1'b0;
            r_rx_prev    <= 1'b0;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= '0;
            r_dbn        <= '0;
            r_pen        <= 1'b0;
            r_ptype      <= 1'b0;
            r_sbn        <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_valid      <= 1'b0;
            rx_data_o    <= '0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_state   <= w_state_nxt;
            if (r_state == IDLE || (r_state == START && w_mid) || w_bit)
                r_tick_cnt <= '0;
            else if (rx_tick)
                r_tick_cnt <= r_tick_cnt + 1'b1;
            if (w_confirm) begin
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
                r_perr     <= 1'b0;
                r_ferr     <= 1'b0;
                r_dbn      <= data_bit_num_i;
                r_pen      <= parity_en_i;
                r_ptype    <= parity_type_i;
                r_sbn      <= stop_bit_num_i;
            end
            if (r_state == DATA && w_bit) begin
                r_shift   <= {r_rx_sync, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == PARITY && w_bit)
                r_perr <= r_rx_sync != (^w_data ^ r_ptype);
            if (r_state == STOP && w_bit) begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
                if (!r_rx_sync)
                    r_ferr <= 1'b1;
            end
            if (w_finish) begin
                rx_data_o    <= DATA_W'(w_data);
                parity_err_o <= r_perr;
                frame_err_o  <= r_ferr | ~r_rx_sync;
            end
            r_valid   <= w_finish | (r_valid & ~rx_read_i);
            overrun_o <= rx_read_i ? 1'b0 : overrun_o | (w_finish & r_valid);
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives randomised and directed UART frames and checks the
// receiver against a frame-level model of data, error flags and handshake.
module tb_uart_rx;
    localparam int BIT_CLKS = 64;
    logic        clk, rst, rx_tick, rx;
    logic [1:0]  data_bit_num_i;
    logic        parity_en_i, parity_type_i, stop_bit_num_i, rx_read_i;
    logic [31:0] rx_data_o;
    logic        rx_valid_o, rx_done_o, parity_err_o, frame_err_o, overrun_o, rts_n;
    int          checks = 0, failures = 0;
    int          tc = 0;
    int          done_cnt = 0, exp_done = 0;
    logic [31:0] exp_data = 0;
    logic        exp_valid = 0, exp_perr = 0, exp_ferr = 0, exp_ovr = 0;

    uart_rx dut (
        .clk(clk), .rst(rst), .rx_tick(rx_tick), .rx(rx),
        .data_bit_num_i(data_bit_num_i), .parity_en_i(parity_en_i),
        .parity_type_i(parity_type_i), .stop_bit_num_i(stop_bit_num_i),
        .rx_read_i(rx_read_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_done_o(rx_done_o), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
        .overrun_o(overrun_o), .rts_n(rts_n)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        rx_tick = 0;
        forever begin
            @(negedge clk);
            tc = (tc == 3) ? 0 : tc + 1;
            rx_tick = (tc == 0);
        end
    end

    always @(negedge clk) if (rx_done_o) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".done"}, 32'(done_cnt), 32'(exp_done));
        chk({tag, ".data"}, rx_data_o, exp_data);
        chk({tag, ".valid"}, 32'(rx_valid_o), 32'(exp_valid));
        chk({tag, ".rts_n"}, 32'(rts_n), 32'(exp_valid));
        chk({tag, ".perr"}, 32'(parity_err_o), 32'(exp_perr));
        chk({tag, ".ferr"}, 32'(frame_err_o), 32'(exp_ferr));
        chk({tag, ".ovr"}, 32'(overrun_o), 32'(exp_ovr));
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic do_read();
        rx_read_i = 1;
        @(negedge clk);
        rx_read_i = 0;
        @(negedge clk);
        exp_valid = 0;
        exp_ovr   = 0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] dbn, input logic pen,
                              input logic podd, input logic sbn, input logic bad_par,
                              input logic bad_stop);
        int n;
        logic [7:0] m;
        logic p;
        n = 5 + int'(dbn);
        m = d & (8'hFF >> (8 - n));
        p = (^m) ^ podd ^ bad_par;
        data_bit_num_i = dbn;
        parity_en_i    = pen;
        parity_type_i  = podd;
        stop_bit_num_i = sbn;
        drive_bit(1'b0);
        data_bit_num_i = 2'($urandom);
        parity_en_i    = 1'($urandom);
        parity_type_i  = 1'($urandom);
        stop_bit_num_i = 1'($urandom);
        for (int i = 0; i < n; i++) drive_bit(m[i]);
        if (pen) drive_bit(p);
        drive_bit(~bad_stop);
        if (sbn) drive_bit(1'b1);
        rx = 1;
        wait_clks(BIT_CLKS);
        exp_ovr   = exp_ovr | exp_valid;
        exp_valid = 1;
        exp_data  = 32'(m);
        exp_perr  = pen & bad_par;
        exp_ferr  = bad_stop;
        exp_done++;
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] dbn;
        logic       pen, podd, sbn, bp, bs;
        rst = 1; rx = 0; rx_read_i = 0;
        data_bit_num_i = 0; parity_en_i = 0; parity_type_i = 0; stop_bit_num_i = 0;
        wait_clks(5);
        check_all("reset");
        rst = 0;
        wait_clks(100);
        rx = 1;
        wait_clks(15 * BIT_CLKS);
        check_all("low_at_release");
        send_frame(8'hA5, 2'd3, 0, 0, 0, 0, 0);
        check_all("8N1_A5");
        do_read();
        check_all("read_A5");
        send_frame(8'h7F, 2'd2, 1, 0, 1, 0, 0);
        check_all("7E2_ok");
        do_read();
        send_frame(8'h7F, 2'd2, 1, 0, 1, 1, 0);
        check_all("7E2_bad_par");
        do_read();
        send_frame(8'h3C, 2'd1, 1, 1, 0, 0, 0);
        check_all("6O1_3C");
        do_read();
        send_frame(8'h1F, 2'd0, 0, 0, 0, 0, 1);
        check_all("5N1_stop_low");
        rx = 0;
        wait_clks(12);
        rx = 1;
        wait_clks(3 * BIT_CLKS);
        check_all("glitch");
        do_read();
        send_frame(8'h11, 2'd3, 0, 0, 0, 0, 0);
        send_frame(8'h22, 2'd3, 0, 0, 0, 0, 0);
        check_all("overrun");
        do_read();
        check_all("overrun_read");
        data_bit_num_i = 2'd3; parity_en_i = 0; stop_bit_num_i = 0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 0;
        wait_clks(BIT_CLKS / 2);
        rst = 1;
        @(negedge clk);
        rst = 0;
        exp_valid = 0; exp_ovr = 0; exp_data = 0; exp_perr = 0; exp_ferr = 0;
        wait_clks(BIT_CLKS / 2);
        rx = 1;
        wait_clks(12 * BIT_CLKS);
        check_all("mid_reset");
        send_frame(8'h5A, 2'd3, 0, 0, 0, 0, 0);
        check_all("after_reset_5A");
        for (int k = 0; k < 10; k++) begin
            d    = 8'($urandom);
            dbn  = 2'($urandom);
            pen  = 1'($urandom);
            podd = 1'($urandom);
            sbn  = 1'($urandom);
            bp   = ($urandom_range(3) == 0);
            bs   = ($urandom_range(3) == 0);
            send_frame(d, dbn, pen, podd, sbn, bp, bs);
            check_all($sformatf("rand%0d", k));
            if ($urandom_range(1) == 1) do_read();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
